mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller that shares the single byte-wide RAM port between instruction fetch (IF, driven by the PC) and data access (MEM, loads/stores). It serialises each 1/2/4-byte request into per-byte RAM cycles and reassembles read data little-endian. It aborts in-flight fetches when EX redirects the PC. It sits between the IF/MEM stages and the external RAM.

## Interface
- AddrLen, 32, address width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request; held high until `if_done_o` or redirect
- if_addr_i  in  AddrLen  fetch address, word-aligned
- if_done_o  out  1  one-cycle pulse; `if_data_o` valid
- if_data_o  out  32  fetched instruction; held until the next IF completion
- mem_req_i  in  1  data request; held until `mem_done_o`
- mem_we_i  in  1  1 = store, 0 = load
- mem_len_i  in  2  00 = byte, 01 = half, 10 = word (11 is treated as word)
- mem_addr_i  in  AddrLen  data address
- mem_wdata_i  in  32  store data; byte i = bits [8i+7:8i]
- mem_done_o  out  1  one-cycle pulse; load data valid or store complete
- mem_rdata_o  out  32  load data, zero-extended; held until the next load completion
- jump_i  in  1  EX redirect; cancels fetch activity
- ram_addr_o  out  AddrLen  RAM byte address (registered)
- ram_wr_o  out  1  RAM write strobe (registered)
- ram_dout_o  out  8  RAM write byte (registered)
- ram_din_i  in  8  RAM read byte

## Operation
- States: IDLE, IF_READ, MEM_READ, MEM_WRITE.
- Arbitration happens only in IDLE, and is skipped in any cycle where `if_done_o` or `mem_done_o` is high.
  - MEM has priority over IF.
  - An IF request is ignored in a cycle where `jump_i` is high.
- Byte count n: 1, 2 or 4 from `mem_len_i`. IF always uses n = 4.
- Latch address, n, we and wdata on entry. Byte i uses address base+i, computed modulo 2^AddrLen.
- Reads:
  - Issue addresses base+0 … base+n−1 on consecutive cycles.
  - Each byte returns on `ram_din_i` one cycle after its address and is captured into bits [8i+7:8i].
  - Unused upper bytes read as 0.
- Writes: drive `ram_wr_o`=1, address base+i and byte i on consecutive cycles.
- Completion:
  - Pulse done for exactly one cycle.
  - Return to IDLE with `ram_wr_o`=0, `ram_addr_o`=0 and `ram_dout_o`=0.
- Redirect:
  - `jump_i` high during IF_READ aborts the fetch; next state is IDLE.
  - No `if_done_o` is produced and captured bytes are discarded.
  - `if_done_o` is combinationally forced low in any cycle `jump_i` is high.
  - `jump_i` never affects MEM transactions.
- Reset: asynchronous.
  - State goes to IDLE; all outputs and data registers go to 0 immediately.
  - An in-flight transaction is dropped without a done pulse.

## Timing
- E0 = the edge at which a request is accepted in IDLE.
- Read of n bytes:
  - Address byte i is visible after E(i).
  - Byte i is captured at E(i+2).
  - Done is high in the cycle after E(n+1), i.e. word = after E5, half = after E3, byte = after E2.
- Write of n bytes:
  - Byte i is written in the cycle after E(i).
  - Done is high in the cycle after E(n), with `ram_wr_o` low in that cycle.
- The earliest next acceptance is the edge ending the done cycle's successor. Requesters drop or replace their request at the edge ending the done cycle.
- An IF request pending behind MEM is accepted at the first legal IDLE edge after MEM completes.
- Reset values: all outputs 0.

## Test plan
- Word fetch:
  - Stimulus: `if_addr_i`=0x100, RAM[0x100..0x103]=13,05,10,00.
  - Required: `ram_addr_o` steps 0x100–0x103; `if_done_o` high exactly one cycle after E5; `if_data_o`=0x00100513, held afterwards.
- Simultaneous requests:
  - Stimulus: IF 0x0 and MEM word load 0x2000 raised in the same cycle.
  - Required: MEM served first; `mem_done_o` after E5; IF accepted only after the gap cycle; `if_done_o` 5 cycles after its own acceptance edge.
- Byte store:
  - Stimulus: `mem_addr_i`=0x1003, `mem_wdata_i`=0x123456AB, len=00.
  - Required: one cycle with `ram_wr_o`=1, addr 0x1003, dout 0xAB; `mem_done_o` the next cycle with `ram_wr_o`=0.
- Half load:
  - Stimulus: RAM[0x2000]=0x34, RAM[0x2001]=0x12.
  - Required: `mem_rdata_o`=0x00001234, done after E3.
- Redirect:
  - Stimulus: `jump_i` pulsed during the third cycle of a fetch at 0x40, then a fetch at 0x80.
  - Required: RAM reads stop; no `if_done_o` for 0x40; 0x80 fetched normally with correct data.
- Reset mid-store:
  - Stimulus: assert `rst` between clock edges during a word store.
  - Required: `ram_wr_o`, `ram_addr_o` and `ram_dout_o` go to 0 before the next edge; no done pulse; a fresh request after reset completes with normal timing.

Source files
------------

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch and data access, MEM first.
// Requests are serialised into per-byte RAM cycles; read bytes are reassembled little-endian.
module mem_ctrl #(
  parameter int AddrLen = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req_i,
  input  logic [AddrLen-1:0] if_addr_i,
  output logic               if_done_o,
  output logic [31:0]        if_data_o,
  input  logic               mem_req_i,
  input  logic               mem_we_i,
  input  logic [1:0]         mem_len_i,
  input  logic [AddrLen-1:0] mem_addr_i,
  input  logic [31:0]        mem_wdata_i,
  output logic               mem_done_o,
  output logic [31:0]        mem_rdata_o,
  input  logic               jump_i,
  output logic [AddrLen-1:0] ram_addr_o,
  output logic               ram_wr_o,
  output logic [7:0]         ram_dout_o,
  input  logic [7:0]         ram_din_i
);

  typedef enum logic [1:0] {IDLE, IF_READ, MEM_READ, MEM_WRITE} state_t;

  state_t             state;
  logic [AddrLen-1:0] base_addr;
  logic [2:0]         n_bytes;
  logic [2:0]         byte_cnt;   // edges seen since acceptance
  logic [31:0]        wdata_q;
  logic [31:0]        rd_buf;
  logic               if_done_q;
  logic               mem_done_q;

  logic [2:0]         n_req;
  logic [1:0]         cap_sel;
  logic [31:0]        merged;
  logic [7:0]         wbyte;
  logic [AddrLen-1:0] next_addr;

  assign if_done_o  = if_done_q & ~jump_i;
  assign mem_done_o = mem_done_q;
  assign cap_sel    = byte_cnt[1:0] - 2'd2;
  assign next_addr  = base_addr + {{(AddrLen-3){1'b0}}, byte_cnt};

  always_comb begin
    n_req = 3'd4;
    case (mem_len_i)
      2'b00:   n_req = 3'd1;
      2'b01:   n_req = 3'd2;
      default: n_req = 3'd4;
    endcase
  end

  // Byte arriving now belongs to the address issued two edges ago.
  always_comb begin
    merged = rd_buf;
    case (cap_sel)
      2'd0:    merged[7:0]   = ram_din_i;
      2'd1:    merged[15:8]  = ram_din_i;
      2'd2:    merged[23:16] = ram_din_i;
      default: merged[31:24] = ram_din_i;
    endcase
  end

  always_comb begin
    wbyte = wdata_q[7:0];
    case (byte_cnt[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      base_addr   <= '0;
      n_bytes     <= '0;
      byte_cnt    <= '0;
      wdata_q     <= '0;
      rd_buf      <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_o   <= '0;
      mem_rdata_o <= '0;
      ram_addr_o  <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= '0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!if_done_o && !mem_done_o) begin
            if (mem_req_i) begin
              base_addr  <= mem_addr_i;
              n_bytes    <= n_req;
              wdata_q    <= mem_wdata_i;
              byte_cnt   <= 3'd1;
              rd_buf     <= '0;
              ram_addr_o <= mem_addr_i;
              if (mem_we_i) begin
                ram_wr_o   <= 1'b1;
                ram_dout_o <= mem_wdata_i[7:0];
                state      <= MEM_WRITE;
              end else begin
                state <= MEM_READ;
              end
            end else if (if_req_i && !jump_i) begin
              base_addr  <= if_addr_i;
              n_bytes    <= 3'd4;
              byte_cnt   <= 3'd1;
              rd_buf     <= '0;
              ram_addr_o <= if_addr_i;
              state      <= IF_READ;
            end
          end
        end
        IF_READ, MEM_READ: begin
          if (state == IF_READ && jump_i) begin
            state      <= IDLE;
            ram_addr_o <= '0;
            rd_buf     <= '0;
          end else begin
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt < n_bytes) ram_addr_o <= next_addr;
            if (byte_cnt >= 3'd2) rd_buf <= merged;
            if (byte_cnt == n_bytes + 3'd1) begin
              state      <= IDLE;
              ram_addr_o <= '0;
              if (state == IF_READ) begin
                if_data_o <= merged;
                if_done_q <= 1'b1;
              end else begin
                mem_rdata_o <= merged;
                mem_done_q  <= 1'b1;
              end
            end
          end
        end
        MEM_WRITE: begin
          byte_cnt <= byte_cnt + 3'd1;
          if (byte_cnt < n_bytes) begin
            ram_addr_o <= next_addr;
            ram_dout_o <= wbyte;
          end else begin
            state      <= IDLE;
            ram_wr_o   <= 1'b0;
            ram_addr_o <= '0;
            ram_dout_o <= '0;
            mem_done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a synchronous byte RAM model and done-driven scoreboards.
module tb_mem_ctrl;

  typedef struct {
    logic        we;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst;
  logic        if_req, if_done, mem_req, mem_we, mem_done, jump, ram_wr;
  logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, ram_addr;
  logic [1:0]  mem_len;
  logic [7:0]  ram_dout, ram_din;

  logic [7:0]  ram [0:65535];
  int          cyc, n_cmp, n_err;
  int          if_dones, mem_dones, if_done_cyc, mem_done_cyc;
  logic [31:0] if_q[$];
  exp_t        mem_q[$];

  mem_ctrl #(.AddrLen(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done), .if_data_o(if_data),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_done_o(mem_done), .mem_rdata_o(mem_rdata),
    .jump_i(jump), .ram_addr_o(ram_addr), .ram_wr_o(ram_wr), .ram_dout_o(ram_dout),
    .ram_din_i(ram_din)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ram_din <= ram[ram_addr[15:0]];
    if (ram_wr) ram[ram_addr[15:0]] <= ram_dout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop and compare whenever a done pulse is seen.
  always @(posedge clk) begin
    #1;
    if (if_done) begin
      if_dones++;
      if_done_cyc = cyc;
      chk("if_q_nonempty", 32'(if_q.size() > 0), 32'd1);
      if (if_q.size() > 0) chk("if_data", if_data, if_q.pop_front());
    end
    if (mem_done) begin
      exp_t e;
      mem_dones++;
      mem_done_cyc = cyc;
      chk("mem_q_nonempty", 32'(mem_q.size() > 0), 32'd1);
      if (mem_q.size() > 0) begin
        e = mem_q.pop_front();
        if (e.we) chk("st_done_wr_low", 32'(ram_wr), 32'd0);
        else      chk("ld_data", mem_rdata, e.data);
      end
    end
  end

  task automatic wait_if(input int start, input int exp_cyc, input string tag);
    for (int k = 0; k < 40 && if_dones == start; k++) @(negedge clk);
    chk({tag, "_seen"}, 32'(if_dones != start), 32'd1);
    chk({tag, "_cyc"}, 32'(if_done_cyc), 32'(exp_cyc));
    if_req = 1'b0;
  endtask

  task automatic wait_mem(input int start, input int exp_cyc, input string tag);
    for (int k = 0; k < 40 && mem_dones == start; k++) @(negedge clk);
    chk({tag, "_seen"}, 32'(mem_dones != start), 32'd1);
    chk({tag, "_cyc"}, 32'(mem_done_cyc), 32'(exp_cyc));
    mem_req = 1'b0;
  endtask

  task automatic mem_load(input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] exp, input int n, input string tag);
    int e0, s;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_len = len; mem_addr = addr;
    mem_q.push_back('{we: 1'b0, data: exp});
    e0 = cyc + 1; s = mem_dones;
    wait_mem(s, e0 + n + 1, tag);
  endtask

  initial begin
    int e0, s;
    exp_t st;
    cyc = 0; n_cmp = 0; n_err = 0; if_dones = 0; mem_dones = 0;
    if_done_cyc = 0; mem_done_cyc = 0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h10; ram[16'h0103] = 8'h00;
    ram[16'h0000] = 8'h11; ram[16'h0001] = 8'h22; ram[16'h0002] = 8'h33; ram[16'h0003] = 8'h44;
    ram[16'h2000] = 8'h34; ram[16'h2001] = 8'h12; ram[16'h2002] = 8'h78; ram[16'h2003] = 8'h56;
    ram[16'h0040] = 8'hDE; ram[16'h0041] = 8'hAD;
    ram[16'h0080] = 8'h93; ram[16'h0081] = 8'h00; ram[16'h0082] = 8'h70; ram[16'h0083] = 8'h00;
    ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'hBB;
    rst = 1'b1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_len = 0;
    mem_addr = 0; mem_wdata = 0; jump = 0; ram_din = 0;

    #12;
    chk("rst_outs", {if_done, mem_done, ram_wr, ram_dout, 21'd0}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Word fetch with address stepping
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; if_q.push_back(32'h00100513);
    e0 = cyc + 1; s = if_dones;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fetch_addr", ram_addr, 32'h100 + 32'(i));
    end
    wait_if(s, e0 + 5, "fetch");
    @(negedge clk);
    chk("fetch_done_one_cycle", 32'(if_done), 32'd0);
    chk("fetch_addr_idle", ram_addr, 32'd0);
    repeat (2) @(negedge clk);
    chk("fetch_data_held", if_data, 32'h00100513);

    // Simultaneous IF and MEM: MEM wins, IF after gap cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0; if_q.push_back(32'h44332211);
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h2000;
    mem_q.push_back('{we: 1'b0, data: 32'h56781234});
    e0 = cyc + 1; s = mem_dones;
    wait_mem(s, e0 + 5, "simul_mem");
    s = if_dones;
    wait_if(s, e0 + 12, "simul_if");

    // Byte store
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h1003; mem_wdata = 32'h123456AB;
    st.we = 1'b1; st.data = 32'h0; mem_q.push_back(st);
    e0 = cyc + 1; s = mem_dones;
    @(negedge clk);
    chk("st_wr", 32'(ram_wr), 32'd1);
    chk("st_addr", ram_addr, 32'h1003);
    chk("st_dout", 32'(ram_dout), 32'hAB);
    wait_mem(s, e0 + 1, "st");
    mem_we = 1'b0;
    chk("st_ram", 32'(ram[16'h1003]), 32'hAB);

    // Loads: half, byte (zero-extended), len=11 as word, wrapping word
    mem_load(2'b01, 32'h2000, 32'h00001234, 2, "ld_half");
    repeat (2) @(negedge clk);
    chk("ld_half_held", mem_rdata, 32'h00001234);
    mem_load(2'b00, 32'h1003, 32'h000000AB, 1, "ld_byte");
    mem_load(2'b11, 32'h0, 32'h44332211, 4, "ld_len3");
    mem_load(2'b10, 32'hFFFFFFFE, 32'h2211BBAA, 4, "ld_wrap");

    // Redirect during third fetch cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40; e0 = cyc + 1; s = if_dones;
    repeat (3) @(negedge clk);
    chk("redir_addr_pre", ram_addr, 32'h42);
    jump = 1'b1;
    @(negedge clk);
    jump = 1'b0; if_addr = 32'h80; if_q.push_back(32'h00700093);
    chk("redir_addr_stop", ram_addr, 32'd0);
    wait_if(s, e0 + 9, "redir_fetch");
    chk("redir_one_done", 32'(if_dones - s), 32'd1);

    // Reset mid-store, then fresh load
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h3000; mem_wdata = 32'hCAFEF00D;
    s = mem_dones;
    repeat (2) @(negedge clk);
    chk("rst_st_wr_pre", 32'(ram_wr), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_st_wr", 32'(ram_wr), 32'd0);
    chk("rst_st_addr", ram_addr, 32'd0);
    chk("rst_st_dout", 32'(ram_dout), 32'd0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_done", 32'(mem_dones - s), 32'd0);
    mem_load(2'b10, 32'h3000, 32'h0000000D, 4, "ld_after_rst");

    repeat (3) @(negedge clk);
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
